cp0_exc_unit: RTL and testbench

Coprocessor-0 exception endpoint for the pipelined MIPS microsystem. It consumes the 5-bit exception code carried down the pipeline by the per-stage exception registers, together with the external hardware interrupt lines. It decides in the M stage whether to take an exception or interrupt, and maintains SR, Cause, EPC and PRId. It provides the mfc0/mtc0 register file port, eret support, the handler entry address and the flush request to the pipeline.

---
 rtl/cp0_exc_unit.sv | 91 +++++++++
 tb/tb_cp0_exc_unit.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/cp0_exc_unit.sv
// Coprocessor-0 exception endpoint: SR/Cause/EPC/PRId, mfc0/mtc0 port and M-stage take decision.
// IntReq and DOut are combinational; register state updates on the next rising edge.
module cp0_exc_unit #(
  parameter logic [31:0] PRID    = 32'h0000_0007,
  parameter logic [31:0] HANDLER = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  input  logic [31:0] DIn,
  input  logic        WE,
  input  logic [31:0] PC,
  input  logic        BD,
  input  logic [4:0]  ExcCode,
  input  logic [5:0]  HWInt,
  input  logic        EXLClr,
  output logic        IntReq,
  output logic [31:0] EPCout,
  output logic [31:0] HandlerPC,
  output logic [31:0] DOut
);

  logic [5:0]  im;
  logic        exl;
  logic        ie;
  logic        cause_bd;
  logic [5:0]  ip;
  logic [4:0]  exc_code;
  logic [31:2] epc;

  logic int_p;
  logic exc_p;
  logic unused_bits;

  assign int_p = (|(HWInt & im)) & ie & ~exl;
  assign exc_p = (ExcCode != 5'd0) & ~exl;

  // Gate with reset so a cleared EXL cannot let a pending ExcCode through while held in reset.
  assign IntReq    = reset & (int_p | exc_p);
  assign EPCout    = {epc, 2'b00};
  assign HandlerPC = HANDLER;

  assign unused_bits = ^{DIn[31:16], DIn[9:2], PC[1:0]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      im       <= '0;
      exl      <= 1'b0;
      ie       <= 1'b0;
      cause_bd <= 1'b0;
      ip       <= '0;
      exc_code <= '0;
      epc      <= '0;
    end else begin
      ip <= HWInt;
      if (IntReq) begin
        exl      <= 1'b1;
        cause_bd <= BD;
        exc_code <= int_p ? 5'd0 : ExcCode;
        // Word-granular EPC: subtracting one word backs up to the branch.
        epc      <= BD ? (PC[31:2] - 30'd1) : PC[31:2];
      end else begin
        if (WE && A2 == 5'd12) begin
          im  <= DIn[15:10];
          exl <= DIn[1];
          ie  <= DIn[0];
        end
        if (WE && A2 == 5'd14) begin
          epc <= DIn[31:2];
        end
        // Placed last so eret overrides an SR write's EXL bit.
        if (EXLClr) begin
          exl <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    DOut = 32'h0;
    case (A1)
      5'd12:   DOut = {16'h0, im, 8'h0, exl, ie};
      5'd13:   DOut = {cause_bd, 15'h0, ip, 3'h0, exc_code, 2'b00};
      5'd14:   DOut = {epc, 2'b00};
      5'd15:   DOut = PRID;
      default: DOut = 32'h0;
    endcase
  end

endmodule

// File: tb/tb_cp0_exc_unit.sv
// Bench for cp0_exc_unit: directed vector table, reset pulse sequence, random run against a register-array model.
module tb_cp0_exc_unit;

  logic        clk;
  logic        reset;
  logic [4:0]  a1;
  logic [4:0]  a2;
  logic [31:0] din;
  logic        we;
  logic [31:0] pc;
  logic        bd;
  logic [4:0]  exc_code;
  logic [5:0]  hw_int;
  logic        exl_clr;
  logic        int_req;
  logic [31:0] epc_out;
  logic [31:0] handler_pc;
  logic [31:0] dout;

  int errors = 0;
  int checks = 0;

  cp0_exc_unit dut (
    .clk       (clk),
    .reset     (reset),
    .A1        (a1),
    .A2        (a2),
    .DIn       (din),
    .WE        (we),
    .PC        (pc),
    .BD        (bd),
    .ExcCode   (exc_code),
    .HWInt     (hw_int),
    .EXLClr    (exl_clr),
    .IntReq    (int_req),
    .EPCout    (epc_out),
    .HandlerPC (handler_pc),
    .DOut      (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [31:0] din;
    logic        we;
    logic [31:0] pc;
    logic        bd;
    logic [4:0]  exc;
    logic [5:0]  hw;
    logic        clr;
    logic        req;
    logic [31:0] dout;
    logic [31:0] epc;
  } vec_t;

  vec_t tbl [27];

  // Model: CP0 register file indexed by register number; unwritten numbers stay 0.
  logic [31:0] mreg [0:31];

  function automatic vec_t mk(input logic [4:0] ra, input logic [4:0] wa, input logic [31:0] d,
                              input logic w, input logic [31:0] p, input logic b, input logic [4:0] e,
                              input logic [5:0] h, input logic c, input logic r,
                              input logic [31:0] o, input logic [31:0] ep);
    vec_t v;
    v.a1 = ra; v.a2 = wa; v.din = d; v.we = w; v.pc = p; v.bd = b; v.exc = e;
    v.hw = h; v.clr = c; v.req = r; v.dout = o; v.epc = ep;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    a1 = v.a1; a2 = v.a2; din = v.din; we = v.we; pc = v.pc; bd = v.bd;
    exc_code = v.exc; hw_int = v.hw; exl_clr = v.clr;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mreg[i] = 32'h0;
    mreg[15] = 32'h0000_0007;
  endtask

  function automatic logic m_intp();
    logic [31:0] sr;
    sr = mreg[12];
    return ((hw_int & sr[15:10]) != 6'd0) && sr[0] && !sr[1];
  endfunction

  function automatic logic m_req();
    return reset && (m_intp() || (exc_code != 5'd0 && !mreg[12][1]));
  endfunction

  task automatic model_edge();
    logic        take;
    logic [31:0] code;
    take = m_req();
    if (take) begin
      code = m_intp() ? 32'd0 : 32'(exc_code);
      mreg[12] = mreg[12] | 32'h2;
      mreg[13] = (bd ? 32'h8000_0000 : 32'h0) | (32'(hw_int) << 10) | (code << 2);
      mreg[14] = (pc & ~32'h3) - (bd ? 32'd4 : 32'd0);
    end else begin
      mreg[13] = (mreg[13] & ~32'h0000_FC00) | (32'(hw_int) << 10);
      if (we && a2 == 5'd12) mreg[12] = din & 32'h0000_FC03;
      if (we && a2 == 5'd14) mreg[14] = din & ~32'h3;
      if (exl_clr) mreg[12] = mreg[12] & ~32'h2;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    reset = 1'b0;
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    model_reset();

    //          a1  a2  din            we pc          bd exc hw clr req dout              epc
    tbl[0]  = mk(15, 0,  32'h0,         0, 32'h0,     0, 0,  0, 0, 0, 32'h0000_0007, 32'h0);
    tbl[1]  = mk(12, 0,  32'h0,         0, 32'h0,     0, 0,  0, 0, 0, 32'h0,         32'h0);
    tbl[2]  = mk(13, 0,  32'h0,         0, 32'h3010,  0, 12, 0, 0, 1, 32'h0,         32'h0);
    tbl[3]  = mk(14, 0,  32'h0,         0, 32'h3010,  0, 12, 0, 0, 0, 32'h3010,      32'h3010);
    tbl[4]  = mk(13, 0,  32'h0,         0, 32'h0,     0, 0,  0, 0, 0, 32'h30,        32'h3010);
    tbl[5]  = mk(12, 0,  32'h0,         0, 32'h0,     0, 0,  0, 1, 0, 32'h2,         32'h3010);
    tbl[6]  = mk(12, 14, 32'hFFFF_FFFF, 1, 32'h3024,  1, 4,  0, 0, 1, 32'h0,         32'h3010);
    tbl[7]  = mk(14, 0,  32'h0,         0, 32'h0,     0, 0,  0, 0, 0, 32'h3020,      32'h3020);
    tbl[8]  = mk(13, 0,  32'h0,         0, 32'h0,     0, 0,  0, 0, 0, 32'h8000_0010, 32'h3020);
    tbl[9]  = mk(12, 12, 32'h401,       1, 32'h0,     0, 0,  0, 0, 0, 32'h2,         32'h3020);
    tbl[10] = mk(12, 0,  32'h0,         0, 32'h0,     0, 0,  1, 0, 1, 32'h401,       32'h3020);
    tbl[11] = mk(13, 0,  32'h0,         0, 32'h0,     0, 0,  1, 0, 0, 32'h400,       32'h0);
    tbl[12] = mk(14, 0,  32'h0,         0, 32'h0,     0, 0,  1, 1, 0, 32'h0,         32'h0);
    tbl[13] = mk(12, 0,  32'h0,         0, 32'h0,     0, 0,  1, 0, 1, 32'h401,       32'h0);
    tbl[14] = mk(13, 0,  32'h0,         0, 32'h0,     0, 0,  0, 1, 0, 32'h400,       32'h0);
    tbl[15] = mk(13, 0,  32'h0,         0, 32'h100,   0, 10, 1, 0, 1, 32'h0,         32'h0);
    tbl[16] = mk(13, 0,  32'h0,         0, 32'h0,     0, 0,  0, 0, 0, 32'h400,       32'h100);
    tbl[17] = mk(14, 12, 32'h400,       1, 32'h0,     0, 0,  0, 0, 0, 32'h100,       32'h100);
    tbl[18] = mk(12, 0,  32'h0,         0, 32'h0,     0, 0,  1, 0, 0, 32'h400,       32'h100);
    tbl[19] = mk(13, 0,  32'h0,         0, 32'h0,     0, 0,  1, 0, 0, 32'h400,       32'h100);
    tbl[20] = mk(3,  0,  32'h0,         0, 32'h0,     0, 0,  0, 0, 0, 32'h0,         32'h100);
    tbl[21] = mk(0,  12, 32'hFC03,      1, 32'h0,     0, 0,  0, 1, 0, 32'h0,         32'h100);
    tbl[22] = mk(12, 0,  32'h0,         0, 32'h0,     0, 0,  0, 0, 0, 32'hFC01,      32'h100);
    tbl[23] = mk(13, 13, 32'hFFFF_FFFF, 1, 32'h0,     0, 0,  0, 0, 0, 32'h0,         32'h100);
    tbl[24] = mk(13, 0,  32'h0,         0, 32'h0,     0, 0,  0, 0, 0, 32'h0,         32'h100);
    tbl[25] = mk(14, 14, 32'h5557,      1, 32'h0,     0, 0,  0, 0, 0, 32'h100,       32'h100);
    tbl[26] = mk(14, 0,  32'h0,         0, 32'h0,     0, 0,  0, 0, 0, 32'h5554,      32'h5554);

    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("handler_pc", handler_pc, 32'h0000_4180);

    for (int i = 0; i < 27; i++) begin
      apply(tbl[i]);
      #2;
      check($sformatf("vec%0d_int_req", i), 32'(int_req), 32'(tbl[i].req));
      check($sformatf("vec%0d_dout", i), dout, tbl[i].dout);
      check($sformatf("vec%0d_epc_out", i), epc_out, tbl[i].epc);
      tick();
    end

    // Asynchronous reset pulse in the middle of a pending exception.
    apply(mk(12, 0, 0, 0, 0, 0, 5, 0, 0, 0, 0, 0));
    #1;
    check("pre_reset_req", 32'(int_req), 32'd1);
    #1;
    reset = 1'b0;
    #1;
    check("reset_req", 32'(int_req), 32'd0);
    check("reset_sr", dout, 32'h0);
    a1 = 5'd13;
    #1;
    check("reset_cause", dout, 32'h0);
    a1 = 5'd14;
    #1;
    check("reset_epc", dout, 32'h0);
    check("reset_epc_out", epc_out, 32'h0);
    a1 = 5'd15;
    #1;
    check("reset_prid", dout, 32'h0000_0007);
    exc_code = 5'd0;
    model_reset();
    reset = 1'b1;
    tick();

    for (int n = 0; n < 400; n++) begin
      a1       = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(12, 15));
      a2       = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(12, 14));
      din      = $urandom;
      we       = ($urandom_range(0, 3) == 0);
      pc       = $urandom;
      bd       = 1'($urandom_range(0, 1));
      exc_code = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
      hw_int   = ($urandom_range(0, 2) == 0) ? 6'($urandom_range(1, 63)) : 6'd0;
      exl_clr  = ($urandom_range(0, 3) == 0);
      #2;
      check("rand_int_req", 32'(int_req), 32'(m_req()));
      check("rand_dout", dout, mreg[a1]);
      check("rand_epc_out", epc_out, mreg[14]);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
